// File: rtl/fic_apb_pkg.sv
// fic_apb_pkg: shared types and defaults for the fabric-side APB3 requester.
// Holds the FSM state encoding, default bus widths and the width of the
// optional ACCESS-phase timeout counter.
package fic_apb_pkg;
    localparam int FIC_ADDR_W = 32;
    localparam int FIC_DATA_W = 32;
    localparam int TMO_W = 16;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
endpackage

// File: rtl/fic_apb_requester.sv
// fic_apb_requester: turns a valid/ready command stream into single APB3
// transfers on the MSS AMBA_MASTER_0 port and returns read data / error
// status on a valid/ready response stream. Traffic is held off until MSS_READY.
// Ports:
//   FIC_0_CLK, FAB_RESET_N (async active-low)  clock and reset
//   MSS_READY                                   gates command acceptance
//   CMD_VALID/READY/WRITE/ADDR/WDATA            command stream
//   RSP_VALID/READY/RDATA/ERR                   response stream
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA            APB request
//   PRDATA/PREADY/PSLVERR                       APB completion
// Optional: define FIC_APB_REQ_TIMEOUT_EN to abort ACCESS phases that wait
// TIMEOUT_CYCLES cycles without PREADY.
module fic_apb_requester
    import fic_apb_pkg::*;
#(
    parameter int ADDR_W = FIC_ADDR_W,
    parameter int DATA_W = FIC_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              FIC_0_CLK,
    input  logic              FAB_RESET_N,
    input  logic              MSS_READY,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    state_t state;
    logic   tmo_hit;

`ifdef FIC_APB_REQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    // counter is zero whenever ACCESS is entered because it is held clear outside ACCESS
    assign tmo_hit = !PREADY && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N)
            tmo_cnt <= '0;
        else if (state != ACCESS)
            tmo_cnt <= '0;
        else if (!PREADY)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            state     <= IDLE;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        PADDR     <= CMD_ADDR;
                        PWRITE    <= CMD_WRITE;
                        // reads leave PWDATA at its previous value
                        if (CMD_WRITE)
                            PWDATA <= CMD_WDATA;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        CMD_READY <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        CMD_READY <= MSS_READY;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        RSP_RDATA <= PWRITE ? '0 : PRDATA;
                        RSP_ERR   <= PSLVERR;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end else if (tmo_hit) begin
                        RSP_RDATA <= '0;
                        RSP_ERR   <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        // reload here so CMD_READY is up in the first IDLE cycle
                        CMD_READY <= MSS_READY;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fic_apb_requester.md
Name: fic_apb_requester

Overview:
- Fabric-side APB3 requester (initiator) driving the system block's AMBA_MASTER_0 APB completer port (PADDR/PSEL/PENABLE/PWRITE/PWDATA in; PRDATA/PREADY/PSLVERR out).
- Converts a valid/ready command stream from fabric logic into single APB3 transfers.
- Returns read data and error status on a valid/ready response stream.
- Holds off all traffic until MSS_READY is asserted.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before abort; used only with the optional feature; legal range 2..65535.

Ports:
- FIC_0_CLK  input  1  sole clock; APB and command/response domains.
- FAB_RESET_N  input  1  asynchronous active-low reset.
- MSS_READY  input  1  MSS ready; no command accepted while low.
- CMD_VALID  input  1  command valid.
- CMD_READY  output  1  command accepted when CMD_VALID && CMD_READY.
- CMD_WRITE  input  1  1 = write, 0 = read.
- CMD_ADDR  input  ADDR_W  transfer address.
- CMD_WDATA  input  DATA_W  write data.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumed when RSP_VALID && RSP_READY.
- RSP_RDATA  output  DATA_W  read data; 0 for writes.
- RSP_ERR  output  1  PSLVERR was sampled, or timeout occurred.
- PADDR  output  ADDR_W  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Reset (async assert, sync deassert handled externally): all outputs 0, FSM = IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CMD_READY = MSS_READY (registered, driven from state).
  - On CMD_VALID && CMD_READY: capture WRITE/ADDR/WDATA into PADDR/PWRITE/PWDATA; PSEL=1, PENABLE=0; go to SETUP.
- SETUP: exactly one cycle. PENABLE=1; go to ACCESS.
- ACCESS:
  - Hold PSEL, PENABLE, PADDR, PWRITE and PWDATA stable while PREADY=0.
  - On PREADY=1: capture PRDATA into RSP_RDATA (only if !PWRITE, else 0); capture PSLVERR into RSP_ERR; PSEL=0, PENABLE=0; RSP_VALID=1; go to RESP.
- RESP:
  - Hold RSP_* until RSP_READY=1.
  - Then RSP_VALID=0 and go to IDLE. CMD_READY rises the following cycle.
  - Registered CMD_READY gives a back-to-back throughput of one transfer per at least 4 cycles with zero wait states.
- Latency: command accept to RSP_VALID = 3 cycles with PREADY=1 on the first ACCESS cycle. Each wait state adds 1.
- PSLVERR is sampled only in the ACCESS cycle where PREADY=1. It is ignored otherwise.
- PWDATA after a read: value is don't-care, held at its last value.
- MSS_READY falling mid-transfer does not abort; the transfer completes normally. Only new acceptance is blocked.
- RSP_READY held high while in IDLE has no effect.
- FAB_RESET_N asserted mid-transfer: PSEL/PENABLE drop immediately (async) and any pending response is discarded.
- One outstanding transfer only; no buffering beyond the single response register.

Optional Feature:
- Macro: FIC_APB_REQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter is cleared on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES-1 with PREADY still 0, the transfer is aborted: PSEL/PENABLE drop, RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0; go to RESP.
  - If PREADY=1 in the same cycle, the normal completion wins.
- Undefined: no counter exists; ACCESS waits indefinitely.

Decomposition:
- Package fic_apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP), 2-bit encoding;
  - ADDR_W and DATA_W defaults;
  - the timeout counter width constant (16).
- Single module, no sub-module. The timeout counter is inline, guarded by the macro.

Test Plan:
- Write, zero wait: CMD addr 0x40000010, wdata 0xA5A5_0001 -> PSEL 1 for 2 cycles, PENABLE in cycle 2, PWRITE=1, RSP_VALID 3 cycles after accept, RSP_ERR=0, RSP_RDATA=0.
- Read with 3 wait states: PREADY low 3 cycles then high with PRDATA=0xDEADBEEF -> APB signals stable throughout, RSP_RDATA=0xDEADBEEF, latency 6 cycles.
- Error: PSLVERR=1 with PREADY=1 -> RSP_ERR=1. PSLVERR=1 with PREADY=0 on the prior cycle -> ignored.
- Backpressure/gating:
  - MSS_READY=0 with CMD_VALID=1 for 10 cycles -> CMD_READY=0 and PSEL=0 throughout.
  - RSP_READY held low for 5 cycles -> RSP_* stable and no new command accepted.
- Reset mid-ACCESS: FAB_RESET_N low during a wait state -> PSEL/PENABLE/RSP_VALID go to 0 without a clock edge; after release, a fresh read completes normally.
- With FIC_APB_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY stuck at 0 -> abort after 8 ACCESS cycles, RSP_ERR=1, RSP_RDATA=0. Without the macro -> still waiting at cycle 100.
